// File: rtl/clock_pkg.sv
// Shared constants and types for the clock/timer front end.
// Default timing constants are derived from the 12 MHz system clock.
package clock_pkg;

  localparam int unsigned CLK_HZ       = 12000000;
  localparam int unsigned DEBOUNCE_20MS = CLK_HZ / 50;
  localparam int unsigned LONG_1S       = CLK_HZ;
  localparam int unsigned REPEAT_200MS  = CLK_HZ / 5;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    HELD_SHORT = 2'd1,
    HELD_LONG  = 2'd2
  } btn_state_t;

endpackage

// File: rtl/debounce_filter.sv
// Two-flop synchroniser plus counting debouncer for one push-button.
// rise_c/fall_c flag the edge on which level is about to flip.
module debounce_filter
  import clock_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_20MS
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic level,
  output logic rise_c,
  output logic fall_c
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;

  logic             s_meta;
  logic             s_sync;
  logic [CNT_W-1:0] deb_cnt;
  logic             flip_c;

  // Level flips once the synced input has disagreed for the full window.
  always_comb begin
    flip_c = (s_sync != level) && (deb_cnt == CNT_W'(DEBOUNCE_CYCLES - 1));
    rise_c = flip_c && s_sync;
    fall_c = flip_c && !s_sync;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_meta  <= 1'b0;
      s_sync  <= 1'b0;
      level   <= 1'b0;
      deb_cnt <= '0;
    end else begin
      s_meta <= btn_raw;
      s_sync <= s_meta;
      if (s_sync == level) begin
        deb_cnt <= '0;
      end else if (flip_c) begin
        level   <= s_sync;
        deb_cnt <= '0;
      end else begin
        deb_cnt <= deb_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/button_conditioner.sv
// Push-button front end: debounced level plus press/release/click/long/repeat
// one-cycle event pulses, all registered and aligned with the level change.
module button_conditioner
  import clock_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_20MS,
  parameter int unsigned LONG_CYCLES     = LONG_1S,
  parameter int unsigned REPEAT_CYCLES   = REPEAT_200MS
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic level,
  output logic press_pulse,
  output logic release_pulse,
  output logic click_pulse,
  output logic long_pulse,
  output logic repeat_pulse
);

  localparam int unsigned HOLD_W = $clog2(LONG_CYCLES) + 1;
  localparam int unsigned RPT_W  = $clog2(REPEAT_CYCLES) + 1;

  logic rise_c;
  logic fall_c;

  btn_state_t        state, state_d;
  logic [HOLD_W-1:0] hold_cnt, hold_d;
  logic [RPT_W-1:0]  rpt_cnt, rpt_d;
  logic              press_d, release_d, click_d, long_d, repeat_d;

  debounce_filter #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk    (clk),
    .rst    (rst),
    .btn_raw(btn_raw),
    .level  (level),
    .rise_c (rise_c),
    .fall_c (fall_c)
  );

  // Hold FSM; a release always takes priority over a coinciding threshold.
  always_comb begin
    state_d   = state;
    hold_d    = hold_cnt;
    rpt_d     = rpt_cnt;
    press_d   = 1'b0;
    release_d = 1'b0;
    click_d   = 1'b0;
    long_d    = 1'b0;
    repeat_d  = 1'b0;
    case (state)
      IDLE: begin
        if (rise_c) begin
          press_d = 1'b1;
          hold_d  = '0;
          state_d = HELD_SHORT;
        end
      end
      HELD_SHORT: begin
        if (fall_c) begin
          release_d = 1'b1;
          click_d   = 1'b1;
          state_d   = IDLE;
        end else if (hold_cnt == HOLD_W'(LONG_CYCLES - 1)) begin
          long_d  = 1'b1;
          rpt_d   = '0;
          state_d = HELD_LONG;
        end else begin
          hold_d = hold_cnt + HOLD_W'(1);
        end
      end
      HELD_LONG: begin
        if (fall_c) begin
          release_d = 1'b1;
          state_d   = IDLE;
        end else if (rpt_cnt == RPT_W'(REPEAT_CYCLES - 1)) begin
          repeat_d = 1'b1;
          rpt_d    = '0;
        end else begin
          rpt_d = rpt_cnt + RPT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      hold_cnt      <= '0;
      rpt_cnt       <= '0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      click_pulse   <= 1'b0;
      long_pulse    <= 1'b0;
      repeat_pulse  <= 1'b0;
    end else begin
      state         <= state_d;
      hold_cnt      <= hold_d;
      rpt_cnt       <= rpt_d;
      press_pulse   <= press_d;
      release_pulse <= release_d;
      click_pulse   <= click_d;
      long_pulse    <= long_d;
      repeat_pulse  <= repeat_d;
    end
  end

endmodule
